// File: rtl/mips_pkg.sv
// Shared types and constants for the MEM-stage data memory arbiter.
// Contents: arbiter FSM state encoding, default starvation limit, counter width,
// and a small word-alignment helper.
package mips_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    // Wide enough for the largest legal starvation limit (15).
    localparam int unsigned STARVE_CNT_W     = 4;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_CPU_RD_WAIT = 2'd1,
        ST_DBG_RD_WAIT = 2'd2
    } arb_state_e;

    // True when the two low byte-address bits select a word boundary.
    function automatic logic is_word_aligned(input logic [1:0] byte_off);
        return (byte_off == 2'b00);
    endfunction

endpackage

// File: rtl/starve_counter.sv
// Saturating starvation counter for the debug port.
// Ports: clk, rst_n (async active-low), i_inc (count one CPU win against a
// waiting debug request), i_clr (debug served or idle; dominates i_inc),
// o_at_limit_c (count has reached LIMIT, decoded from the count register).
module starve_counter
    import mips_pkg::*;
#(
    parameter int unsigned LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit_c
);

    localparam logic [STARVE_CNT_W-1:0] LIMIT_V = STARVE_CNT_W'(LIMIT);

    logic [STARVE_CNT_W-1:0] r_cnt;

    // Count register: clear wins, otherwise increment up to the limit and hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != LIMIT_V)) begin
            r_cnt <= r_cnt + STARVE_CNT_W'(1);
        end
    end

    assign o_at_limit_c = (r_cnt == LIMIT_V);

endmodule

// File: rtl/dmem_arbiter.sv
// Data memory arbiter between the MEM-stage CPU port and a debug/loader port
// sharing one single-port synchronous RAM (read data one cycle after issue).
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   memRead/memWrite/aluRes/readData2Reg  CPU MEM-stage request (byte address)
//   cpuStall, cpuReadData, cpuReadValid, cpuMisalign  CPU responses
//   dbgReq/dbgWe/dbgAddr/dbgWdata      debug request (word address)
//   dbgGnt, dbgRdata, dbgRvalid        debug responses
//   memEn/memWe/memAddr/memWdata/memRdata  RAM port
// Responses are decoded from the registered FSM state and the live requests;
// memRdata only feeds the read-data outputs, never the RAM controls.
module dmem_arbiter
    import mips_pkg::*;
#(
    parameter int unsigned ADDR_W       = 10,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [DATA_W-1:0] aluRes,
    input  logic [DATA_W-1:0] readData2Reg,
    output logic              cpuStall,
    output logic [DATA_W-1:0] cpuReadData,
    output logic              cpuReadValid,
    output logic              cpuMisalign,
    input  logic              dbgReq,
    input  logic              dbgWe,
    input  logic [ADDR_W-1:0] dbgAddr,
    input  logic [DATA_W-1:0] dbgWdata,
    output logic              dbgGnt,
    output logic [DATA_W-1:0] dbgRdata,
    output logic              dbgRvalid,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata
);

    arb_state_e r_state;
    arb_state_e w_state_nxt;

    logic w_cpu_req;
    logic w_cpu_aligned;
    logic w_cpu_go;
    logic w_cnt_inc;
    logic w_cnt_clr;
    logic w_starved;
    logic w_unused_ok;

    // A simultaneous read+write request is a write.
    assign w_cpu_req     = memRead | memWrite;
    assign w_cpu_aligned = is_word_aligned(aluRes[1:0]);
    assign w_unused_ok   = &{1'b0, aluRes[DATA_W-1:ADDR_W+2]};

    starve_counter #(
        .LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_inc        (w_cnt_inc),
        .i_clr        (w_cnt_clr),
        .o_at_limit_c (w_starved)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Arbitration, next state and output decode; everything is held at zero
    // while reset is asserted, independent of the live request inputs.
    always_comb begin
        w_state_nxt  = r_state;
        w_cpu_go     = 1'b0;
        w_cnt_inc    = 1'b0;
        w_cnt_clr    = ~dbgReq;
        cpuStall     = 1'b0;
        cpuReadData  = '0;
        cpuReadValid = 1'b0;
        cpuMisalign  = 1'b0;
        dbgGnt       = 1'b0;
        dbgRdata     = '0;
        dbgRvalid    = 1'b0;
        memEn        = 1'b0;
        memWe        = 1'b0;
        memAddr      = '0;
        memWdata     = '0;

        if (rst_n) begin
            case (r_state)
                ST_IDLE: begin
                    cpuMisalign = w_cpu_req & ~w_cpu_aligned;
                    // CPU wins unless the debug port has been starved to the limit.
                    w_cpu_go = w_cpu_req & w_cpu_aligned & ~(dbgReq & w_starved);
                    if (w_cpu_go) begin
                        memEn     = 1'b1;
                        memWe     = memWrite;
                        memAddr   = aluRes[ADDR_W+1:2];
                        memWdata  = memWrite ? readData2Reg : '0;
                        w_cnt_inc = dbgReq;
                        if (!memWrite) begin
                            cpuStall    = 1'b1;
                            w_state_nxt = ST_CPU_RD_WAIT;
                        end
                    end else if (dbgReq) begin
                        dbgGnt    = 1'b1;
                        memEn     = 1'b1;
                        memWe     = dbgWe;
                        memAddr   = dbgAddr;
                        memWdata  = dbgWe ? dbgWdata : '0;
                        w_cnt_clr = 1'b1;
                        cpuStall  = w_cpu_req & w_cpu_aligned;
                        if (!dbgWe) begin
                            w_state_nxt = ST_DBG_RD_WAIT;
                        end
                    end
                end
                ST_CPU_RD_WAIT: begin
                    // The request still visible here is the load being completed.
                    cpuReadData  = memRdata;
                    cpuReadValid = 1'b1;
                    w_state_nxt  = ST_IDLE;
                end
                ST_DBG_RD_WAIT: begin
                    dbgRdata    = memRdata;
                    dbgRvalid   = 1'b1;
                    cpuStall    = w_cpu_req & w_cpu_aligned;
                    cpuMisalign = w_cpu_req & ~w_cpu_aligned;
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous RAM.
// Inputs change 1 time unit after each rising edge; outputs are checked on the
// falling edge of the same cycle.
module tb_dmem_arbiter;

    localparam int unsigned ADDR_W = 10;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              memRead, memWrite;
    logic [31:0]       aluRes, readData2Reg;
    logic              cpuStall, cpuReadValid, cpuMisalign;
    logic [31:0]       cpuReadData;
    logic              dbgReq, dbgWe;
    logic [ADDR_W-1:0] dbgAddr;
    logic [31:0]       dbgWdata;
    logic              dbgGnt, dbgRvalid;
    logic [31:0]       dbgRdata;
    logic              memEn, memWe;
    logic [ADDR_W-1:0] memAddr;
    logic [31:0]       memWdata, memRdata;

    logic              pre_we;
    logic [ADDR_W-1:0] pre_addr;
    logic [31:0]       pre_data;
    logic [31:0]       ram [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W       (ADDR_W),
        .STARVE_LIMIT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .aluRes       (aluRes),
        .readData2Reg (readData2Reg),
        .cpuStall     (cpuStall),
        .cpuReadData  (cpuReadData),
        .cpuReadValid (cpuReadValid),
        .cpuMisalign  (cpuMisalign),
        .dbgReq       (dbgReq),
        .dbgWe        (dbgWe),
        .dbgAddr      (dbgAddr),
        .dbgWdata     (dbgWdata),
        .dbgGnt       (dbgGnt),
        .dbgRdata     (dbgRdata),
        .dbgRvalid    (dbgRvalid),
        .memEn        (memEn),
        .memWe        (memWe),
        .memAddr      (memAddr),
        .memWdata     (memWdata),
        .memRdata     (memRdata)
    );

    // Single-port synchronous RAM with a bench-side preload port.
    always @(posedge clk) begin
        if (pre_we) begin
            ram[pre_addr] <= pre_data;
        end else if (memEn) begin
            if (memWe) ram[memAddr] <= memWdata;
            else       memRdata     <= ram[memAddr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        memRead      = 1'b0;
        memWrite     = 1'b0;
        aluRes       = '0;
        readData2Reg = '0;
        dbgReq       = 1'b0;
        dbgWe        = 1'b0;
        dbgAddr      = '0;
        dbgWdata     = '0;
    endtask

    initial begin
        rst_n    = 1'b0;
        pre_we   = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        clear_inputs();

        // Reset holds every output at zero even with live requests.
        memRead = 1'b1; aluRes = 32'd20; dbgReq = 1'b1; dbgAddr = 10'd9;
        mid();
        chk("rst_memEn",    32'(memEn),    32'd0);
        chk("rst_cpuStall", 32'(cpuStall), 32'd0);
        chk("rst_dbgGnt",   32'(dbgGnt),   32'd0);
        chk("rst_memAddr",  32'(memAddr),  32'd0);
        clear_inputs();

        // Preload RAM[5] and RAM[7] while in reset.
        tick(); pre_we = 1'b1; pre_addr = 10'd5; pre_data = 32'h1234;
        tick(); pre_addr = 10'd7; pre_data = 32'hA5;
        tick(); pre_we = 1'b0;
        rst_n = 1'b1;

        // Idle: no requests.
        mid();
        chk("idle_memEn",    32'(memEn),    32'd0);
        chk("idle_cpuStall", 32'(cpuStall), 32'd0);
        chk("idle_dbgGnt",   32'(dbgGnt),   32'd0);

        // Misaligned load is dropped.
        tick(); memRead = 1'b1; aluRes = 32'd5;
        mid();
        chk("mis_pulse",    32'(cpuMisalign), 32'd1);
        chk("mis_memEn",    32'(memEn),       32'd0);
        chk("mis_cpuStall", 32'(cpuStall),    32'd0);
        tick(); clear_inputs();
        mid();
        chk("mis_gone", 32'(cpuMisalign), 32'd0);

        // Aligned store issues in the same cycle without stalling.
        tick(); memWrite = 1'b1; aluRes = 32'd20; readData2Reg = 32'd8;
        mid();
        chk("st_memEn",    32'(memEn),    32'd1);
        chk("st_memWe",    32'(memWe),    32'd1);
        chk("st_memAddr",  32'(memAddr),  32'd5);
        chk("st_memWdata", memWdata,      32'd8);
        chk("st_cpuStall", 32'(cpuStall), 32'd0);
        tick(); clear_inputs();

        // Aligned load: stall in the issue cycle, data the cycle after.
        tick(); memRead = 1'b1; aluRes = 32'd20;
        mid();
        chk("ld1_cpuStall", 32'(cpuStall),     32'd1);
        chk("ld1_memEn",    32'(memEn),        32'd1);
        chk("ld1_memWe",    32'(memWe),        32'd0);
        chk("ld1_memAddr",  32'(memAddr),      32'd5);
        chk("ld1_valid",    32'(cpuReadValid), 32'd0);
        tick();
        mid();
        chk("ld2_valid",    32'(cpuReadValid), 32'd1);
        chk("ld2_data",     cpuReadData,       32'd8);
        chk("ld2_cpuStall", 32'(cpuStall),     32'd0);
        chk("ld2_memEn",    32'(memEn),        32'd0);
        tick(); clear_inputs();
        mid();
        chk("ld3_valid", 32'(cpuReadValid), 32'd0);

        // Continuous stores against a pending debug write: four CPU wins, then debug.
        tick();
        memWrite = 1'b1; aluRes = 32'd40; readData2Reg = 32'h11;
        dbgReq = 1'b1; dbgWe = 1'b1; dbgAddr = 10'd3; dbgWdata = 32'h77;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("stv_cpu_dbgGnt",  32'(dbgGnt),   32'd0);
            chk("stv_cpu_memAddr", 32'(memAddr),  32'd10);
            chk("stv_cpu_stall",   32'(cpuStall), 32'd0);
            tick();
        end
        mid();
        chk("stv_dbg_gnt",     32'(dbgGnt),   32'd1);
        chk("stv_dbg_stall",   32'(cpuStall), 32'd1);
        chk("stv_dbg_memAddr", 32'(memAddr),  32'd3);
        chk("stv_dbg_memWe",   32'(memWe),    32'd1);
        chk("stv_dbg_wdata",   memWdata,      32'h77);
        tick(); dbgReq = 1'b0;
        mid();
        chk("stv_after_gnt",   32'(dbgGnt),   32'd0);
        chk("stv_after_addr",  32'(memAddr),  32'd10);
        chk("stv_after_stall", 32'(cpuStall), 32'd0);

        // Debug read: counter restarts from zero, then debug beats a pending load.
        tick();
        aluRes = 32'd44; readData2Reg = 32'h22;
        dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 10'd7;
        for (int i = 0; i < 4; i++) begin
            mid();
            chk("dr_cpu_dbgGnt",  32'(dbgGnt),  32'd0);
            chk("dr_cpu_memAddr", 32'(memAddr), 32'd11);
            tick();
        end
        memWrite = 1'b0; memRead = 1'b1; aluRes = 32'd20;
        mid();
        chk("dr_gnt",      32'(dbgGnt),   32'd1);
        chk("dr_memWe",    32'(memWe),    32'd0);
        chk("dr_memAddr",  32'(memAddr),  32'd7);
        chk("dr_cpuStall", 32'(cpuStall), 32'd1);
        tick(); dbgReq = 1'b0;
        mid();
        chk("dr_rvalid",    32'(dbgRvalid), 32'd1);
        chk("dr_rdata",     dbgRdata,       32'hA5);
        chk("dr_w_stall",   32'(cpuStall),  32'd1);
        chk("dr_w_memEn",   32'(memEn),     32'd0);
        chk("dr_w_gnt",     32'(dbgGnt),    32'd0);
        tick();
        mid();
        chk("dr_ld_memEn",  32'(memEn),     32'd1);
        chk("dr_ld_addr",   32'(memAddr),   32'd5);
        chk("dr_ld_stall",  32'(cpuStall),  32'd1);
        chk("dr_rvalid_off", 32'(dbgRvalid), 32'd0);
        tick();
        mid();
        chk("dr_ld_valid", 32'(cpuReadValid), 32'd1);
        chk("dr_ld_data",  cpuReadData,       32'd8);
        chk("dr_ld_nostall", 32'(cpuStall),   32'd0);
        tick(); clear_inputs();

        // Reset while waiting on a CPU load abandons the read.
        tick(); memRead = 1'b1; aluRes = 32'd20;
        mid();
        chk("rr_stall", 32'(cpuStall), 32'd1);
        tick();
        #1 rst_n = 1'b0;
        #1;
        chk("rr_valid", 32'(cpuReadValid), 32'd0);
        chk("rr_data",  cpuReadData,       32'd0);
        chk("rr_stall0", 32'(cpuStall),    32'd0);
        chk("rr_memEn", 32'(memEn),        32'd0);
        clear_inputs();
        tick();
        rst_n = 1'b1;
        mid();
        chk("rr_post_valid", 32'(cpuReadValid), 32'd0);
        chk("rr_post_memEn", 32'(memEn),        32'd0);
        tick(); dbgReq = 1'b1; dbgWe = 1'b0; dbgAddr = 10'd3;
        mid();
        chk("rr_dbg_gnt",  32'(dbgGnt),  32'd1);
        chk("rr_dbg_addr", 32'(memAddr), 32'd3);
        tick(); dbgReq = 1'b0;
        mid();
        chk("rr_dbg_rvalid", 32'(dbgRvalid), 32'd1);
        chk("rr_dbg_rdata",  dbgRdata,       32'h77);
        tick();
        mid();
        chk("rr_dbg_rvalid_off", 32'(dbgRvalid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 10: data memory word-address width.
REQ-002 Parameter STARVE_LIMIT, default 4: consecutive CPU grants against a pending debug request before debug is forced (legal range 1..15).
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 memRead, memWrite  in  1 each  MEM-stage load/store request, held until the arbiter releases the stall.
REQ-006 aluRes  in  32  MEM-stage byte address; readData2Reg  in  32  MEM-stage store data.
REQ-007 cpuStall  out  1  freeze IF..MEM pipeline registers this cycle.
REQ-008 cpuReadData  out  32  load data; cpuReadValid  out  1  one-cycle qualifier.
REQ-009 cpuMisalign  out  1  one-cycle pulse for a dropped misaligned CPU access.
REQ-010 dbgReq, dbgWe  in  1 each; dbgAddr  in  ADDR_W  word address; dbgWdata  in  32  debug/loader port, held until dbgGnt.
REQ-011 dbgGnt  out  1; dbgRdata  out  32; dbgRvalid  out  1  debug grant, read data, read qualifier.
REQ-012 memEn, memWe  out  1 each; memAddr  out  ADDR_W; memWdata  out  32; memRdata  in  32  single-port synchronous RAM, read data valid the cycle after issue.

Function
REQ-013 States: IDLE, CPU_RD_WAIT, DBG_RD_WAIT; at most one memory issue per cycle, issues only in IDLE.
REQ-014 CPU request = memRead | memWrite; memRead & memWrite together is treated as a write.
REQ-015 CPU word address = aluRes[ADDR_W+1:2]; aluRes[1:0] != 0 -> no issue, cpuMisalign = 1 for one cycle, cpuStall = 0 that cycle.
REQ-016 Arbitration in IDLE: CPU wins over debug unless starveCnt == STARVE_LIMIT, in which case debug wins.
REQ-017 starveCnt increments on each CPU issue while dbgReq = 1, saturates at STARVE_LIMIT, clears on any debug issue or whenever dbgReq = 0.
REQ-018 CPU write issue: memEn = 1, memWe = 1, cpuStall = 0 same cycle, state stays IDLE.
REQ-019 CPU read issue: memEn = 1, memWe = 0, cpuStall = 1, next state CPU_RD_WAIT.
REQ-020 CPU_RD_WAIT: cpuReadData = memRdata, cpuReadValid = 1, cpuStall = 0, memEn = 0, next state IDLE; load latency is exactly 2 cycles.
REQ-021 Debug issue: dbgGnt = 1 for one cycle; write -> state stays IDLE; read -> DBG_RD_WAIT, where dbgRdata = memRdata, dbgRvalid = 1, next state IDLE.
REQ-022 cpuStall = 1 in any cycle with a valid aligned CPU request that is not issued (lost arbitration, or state != IDLE), and in the CPU read issue cycle.
REQ-023 With no requests: memEn = 0, all strobes 0, state IDLE.
REQ-024 dbgGnt, cpuReadValid, dbgRvalid, cpuMisalign are single-cycle pulses, never asserted twice for one request.

Reset
REQ-025 rst_n low asynchronously forces state IDLE, starveCnt 0, all outputs 0 (memEn, memWe, cpuStall, valids, dbgGnt, cpuMisalign, data buses).
REQ-026 Reset during CPU_RD_WAIT or DBG_RD_WAIT abandons the read, with no valid pulse after release.
REQ-027 First arbitration occurs on the first rising edge with rst_n high.

Structure
REQ-028 State encoding enum and default STARVE_LIMIT live in shared package mips_pkg.
REQ-029 One sub-module, starve_counter: saturating counter with inc/clr/limit-reached.
REQ-030 Outputs decoded from registered state plus current requests; no combinational path from memRdata to memEn.

Verification
REQ-031 memRead = 1, aluRes = 5 -> cpuMisalign pulse, memEn = 0, cpuStall = 0.
REQ-032 memWrite = 1, aluRes = 20, readData2Reg = 8 -> same cycle memEn = 1, memWe = 1, memAddr = 5, memWdata = 8, cpuStall = 0.
REQ-033 memRead = 1, aluRes = 20, RAM[5] = 8 -> cycle 1: cpuStall = 1; cycle 2: cpuReadValid = 1, cpuReadData = 8, cpuStall = 0.
REQ-034 Continuous CPU writes plus dbgReq = 1 (write, dbgAddr = 3) -> CPU issues 4 times, 5th slot dbgGnt = 1 with cpuStall = 1, then starveCnt = 0.
REQ-035 Debug read, dbgAddr = 7, RAM[7] = 0xA5 -> dbgGnt, next cycle dbgRvalid = 1, dbgRdata = 0xA5; a concurrent CPU load stalls 2 extra cycles.
REQ-036 rst_n low during CPU_RD_WAIT -> outputs 0 immediately, no cpuReadValid after release, IDLE.
